// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order imem requests under a credit limit,
// buffers returned instructions with their PCs in a prefetch FIFO and honours EX redirects.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  cnt_t        outstanding_q, outstanding_d;
  cnt_t        discard_q, discard_d;
  cnt_t        count_q, count_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  entry_t      fifo_q [DEPTH];

  logic [CW:0] in_use;
  logic        credit_ok;
  logic        req_fire;
  logic        rsp_ok;
  logic        push;
  logic        pop;
  logic [31:0] redirect_tgt;
  entry_t      head;

  // Every slot is pre-claimed by a request, so buffered plus in-flight never exceeds DEPTH.
  assign in_use    = {1'b0, outstanding_q} + {1'b0, count_q};
  assign credit_ok = in_use < {1'b0, DEPTH_C};

  assign imem_req_valid = reset_n && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored outright.
  assign rsp_ok = imem_rsp_valid && (outstanding_q != '0);
  assign push   = rsp_ok && !redirect_valid && (discard_q == '0);

  assign id_valid = (count_q != '0);
  assign pop      = id_valid && id_ready;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  assign head     = fifo_q[rd_ptr_q];
  assign id_instr = id_valid ? head.instr : 32'h0;
  assign id_pc    = id_valid ? head.pc    : 32'h0;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(rsp_ok);

    if (redirect_valid) begin
      // No request fires this cycle, so everything still in flight after this edge is stale.
      fetch_pc_d = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      discard_d  = outstanding_q - cnt_t'(rsp_ok);
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_ok && (discard_q != '0)) discard_d = discard_q - cnt_t'(1);
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + ptr_t'(1);
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // NOTE: FIFO storage is not reset; id_* are masked to zero whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= '{pc: rsp_pc_q, instr: imem_rsp_data};
  end

endmodule
